// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a shared N-bit ALU.
// Each operation takes IDLE -> EXEC -> RESP and returns one registered, held response.
module alu_req_arbiter #(
  parameter int N   = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_y,
  output logic           rsp_zero,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] OP_NOT  = OPW'(0);
  localparam logic [OPW-1:0] OP_AND  = OPW'(1);
  localparam logic [OPW-1:0] OP_OR   = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5);
  localparam logic [OPW-1:0] OP_PASS = OPW'(6);

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic           grant_id;
  logic           accept;

  logic [OPW-1:0] op_q;
  logic [N-1:0]   a_q, b_q;
  logic           id_q;

  logic           rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_carry_q, rsp_err_q;
  logic [N-1:0]   rsp_y_q;

  logic [N:0]     add_w, sub_w;
  logic [N-1:0]   y_w;
  logic           carry_w, err_w;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = ~req0_valid;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
    y_w     = '0;
    carry_w = 1'b0;
    err_w   = 1'b0;
    case (op_q)
      OP_NOT:  y_w = ~a_q;
      OP_AND:  y_w = a_q & b_q;
      OP_OR:   y_w = a_q | b_q;
      OP_XOR:  y_w = a_q ^ b_q;
      OP_ADD:  {carry_w, y_w} = add_w;
      OP_SUB:  {carry_w, y_w} = sub_w;
      OP_PASS: y_w = a_q;
      default: err_w = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (grant_id) begin
          op_q <= req1_op;
          a_q  <= req1_a;
          b_q  <= req1_b;
        end else begin
          op_q <= req0_op;
          a_q  <= req0_a;
          b_q  <= req0_b;
        end
        id_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_y_q     <= y_w;
        rsp_zero_q  <= (y_w == '0);
        rsp_carry_q <= carry_w;
        rsp_err_q   <= err_w;
      end
      // Fairness pointer only advances once the response is actually consumed.
      if (state_q == RESP && rsp_ready) begin
        rsp_valid_q  <= 1'b0;
        last_grant_q <= rsp_id_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed table, multi-cycle corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_y;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.N(8), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
    logic       c;
    logic       e;
  } vec_t;

  typedef struct {
    int id;
    int y;
    int z;
    int c;
    int e;
    int acc;
  } exp_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU from the opcode table using plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int y, output int z, output int c, output int e);
    int r;
    c = 0;
    e = 0;
    case (op)
      0: r = 255 - a;
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
      5: begin c = (a >= b) ? 1 : 0; r = (a - b + 256) % 256; end
      6: r = a;
      default: begin r = 0; e = 1; end
    endcase
    y = r;
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int p, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("accept_seen", {31'b0, seen}, 1);
  endtask

  task automatic single(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] y, output logic z, output logic c,
                        output logic e, output logic id);
    bit seen;
    y = '0; z = 1'b0; c = 1'b0; e = 1'b0; id = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    wait_ready(p, seen);
    if (seen) begin
      chk("other_ready_low", {31'b0, (p == 0) ? req1_ready : req0_ready}, 0);
      chk("rsp_valid_at_accept", {31'b0, rsp_valid}, 0);
      chk("busy_at_accept", {31'b0, busy}, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!seen) return;
    @(negedge clk);
    chk("rsp_valid_T+1", {31'b0, rsp_valid}, 0);
    chk("busy_exec", {31'b0, busy}, 1);
    @(negedge clk);
    chk("rsp_valid_T+2", {31'b0, rsp_valid}, 1);
    y = rsp_y; z = rsp_zero; c = rsp_carry; e = rsp_err; id = rsp_id;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] y;
    logic       z, c, e, id;
    bit         seen;
    int         gexp, rexp, ng, nr;
    int         lg;
    bit         mbusy;
    exp_t       q[$];
    bit         pend[2], accd[2];
    logic [2:0] pop[2];
    logic [7:0] pa[2], pb[2];

    vt[0]  = '{3'd0, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{3'd2, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{3'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{3'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{3'd4, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{3'd5, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{3'd5, 8'h05, 8'h03, 8'h02, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{3'd5, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{3'd6, 8'h80, 8'h11, 8'h80, 1'b0, 1'b0, 1'b0};
    vt[10] = '{3'd7, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[11] = '{3'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    reset_dut();
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_rsp_id",    {31'b0, rsp_id}, 0);
    chk("reset_rsp_y",     {24'b0, rsp_y}, 0);
    chk("reset_flags",     {29'b0, rsp_zero, rsp_carry, rsp_err}, 0);
    chk("reset_busy",      {31'b0, busy}, 0);
    chk("reset_readys",    {30'b0, req0_ready, req1_ready}, 0);

    // Table: one operation at a time on port 0
    for (int i = 0; i < 12; i++) begin
      single(0, vt[i].op, vt[i].a, vt[i].b, y, z, c, e, id);
      chk($sformatf("vec%0d_y", i), {24'b0, y}, {24'b0, vt[i].y});
      chk($sformatf("vec%0d_zce", i), {29'b0, z, c, e}, {29'b0, vt[i].z, vt[i].c, vt[i].e});
      chk($sformatf("vec%0d_id", i), {31'b0, id}, 0);
    end

    // Ties after reset: port 0 first, then strict alternation
    reset_dut();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'hFF; req0_b = 8'h01;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 8'hFF; req1_b = 8'h01;
    rsp_ready = 1'b1;
    gexp = 0; rexp = 0; ng = 0; nr = 0;
    for (int i = 0; i < 40 && nr < 6; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("tie_grant", {31'b0, req1_ready}, gexp);
        chk("tie_one_ready", {31'b0, req0_ready & req1_ready}, 0);
        gexp ^= 1; ng++;
      end
      if (rsp_valid) begin
        chk("tie_rsp_id", {31'b0, rsp_id}, rexp);
        chk("tie_rsp_y", {24'b0, rsp_y}, 0);
        chk("tie_rsp_zc", {30'b0, rsp_zero, rsp_carry}, 3);
        rexp ^= 1; nr++;
      end
    end
    chk("tie_responses", nr, 6);
    chk("tie_grants", ng, 6);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: response held, port 0 held off and served afterwards
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'h0F; req1_b = 8'hF0;
    wait_ready(1, seen);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 8'h33; req0_b = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
      chk("bp_ready_low_wait", {30'b0, req0_ready, req1_ready}, 0);
    end
    chk("bp_rsp_seen", {31'b0, seen}, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 1);
      chk("bp_hold_y", {24'b0, rsp_y}, 32'hFF);
      chk("bp_hold_id", {31'b0, rsp_id}, 1);
      chk("bp_hold_flags", {29'b0, rsp_zero, rsp_carry, rsp_err}, 0);
      chk("bp_readys", {30'b0, req0_ready, req1_ready}, 0);
      chk("bp_busy", {31'b0, busy}, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, rsp_valid}, 1);
    @(negedge clk);
    chk("bp_idle_busy", {31'b0, busy}, 0);
    chk("bp_idle_valid", {31'b0, rsp_valid}, 0);
    chk("bp_heldoff_ready0", {31'b0, req0_ready}, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_valid", {31'b0, rsp_valid}, 1);
    chk("bp_second_y", {24'b0, rsp_y}, 32'h33);
    chk("bp_second_id", {31'b0, rsp_id}, 0);

    // Reset during EXEC: op discarded, port 0 wins the next tie again
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h01; req0_b = 8'h01;
    wait_ready(0, seen);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h77; req1_b = 8'h00;
    @(negedge clk);
    chk("rst_exec_valid", {31'b0, rsp_valid}, 0);
    chk("rst_exec_busy", {31'b0, busy}, 0);
    chk("rst_exec_tie", {30'b0, req0_ready, req1_ready}, 2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_no_stale", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    chk("rst_exec_next_valid", {31'b0, rsp_valid}, 1);
    chk("rst_exec_next_y", {24'b0, rsp_y}, 32'h30);
    chk("rst_exec_next_id", {31'b0, rsp_id}, 0);

    // Reset during RESP with the response pending
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd5; req0_a = 8'h09; req0_b = 8'h04;
    wait_ready(0, seen);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_pending", {31'b0, rsp_valid}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'hFF; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h77; req1_b = 8'h00;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_resp_y", {24'b0, rsp_y}, 0);
    chk("rst_resp_busy", {31'b0, busy}, 0);
    chk("rst_resp_tie", {30'b0, req0_ready, req1_ready}, 2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_next_y", {24'b0, rsp_y}, 32'hF0);
    chk("rst_resp_next_id", {31'b0, rsp_id}, 0);

    // Randomized traffic against the transaction-level model
    reset_dut();
    lg = 1; mbusy = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; accd[0] = 1'b0; accd[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int any, g, exp_rv, ey, ez, ec, ee;
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      for (int p = 0; p < 2; p++) begin
        if (accd[p]) pend[p] = 1'b0;
        accd[p] = 1'b0;
        if (!pend[p] && cyc < 560 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pop[p] = 3'($urandom_range(0, 7));
          pa[p] = 8'($urandom);
          pb[p] = 8'($urandom);
        end
      end
      req0_valid = pend[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
      req1_valid = pend[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
      rsp_ready = (cyc >= 560) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      any = (!mbusy && (pend[0] || pend[1])) ? 1 : 0;
      g = (pend[0] && pend[1]) ? 1 - lg : (pend[0] ? 0 : 1);
      chk("rnd_busy", {31'b0, busy}, {31'b0, mbusy});
      chk("rnd_ready0", {31'b0, req0_ready}, (any == 1 && g == 0) ? 1 : 0);
      chk("rnd_ready1", {31'b0, req1_ready}, (any == 1 && g == 1) ? 1 : 0);
      exp_rv = (q.size() > 0 && cyc >= q[0].acc + 2) ? 1 : 0;
      chk("rnd_rsp_valid", {31'b0, rsp_valid}, exp_rv);
      if (exp_rv == 1 && rsp_valid) begin
        chk("rnd_rsp_id", {31'b0, rsp_id}, q[0].id);
        chk("rnd_rsp_y", {24'b0, rsp_y}, q[0].y);
        chk("rnd_rsp_zce", {29'b0, rsp_zero, rsp_carry, rsp_err},
            (q[0].z << 2) | (q[0].c << 1) | q[0].e);
      end
      if (any == 1) begin
        ref_alu(int'(pop[g]), int'(pa[g]), int'(pb[g]), ey, ez, ec, ee);
        q.push_back('{g, ey, ez, ec, ee, cyc});
        accd[g] = 1'b1;
        mbusy = 1'b1;
      end
      if (exp_rv == 1 && rsp_ready) begin
        lg = q[0].id;
        void'(q.pop_front());
        mbusy = 1'b0;
      end
    end
    chk("rnd_drain", q.size(), 0);
    chk("rnd_pending", {30'b0, pend[0] & ~accd[0], pend[1] & ~accd[1]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
